// File: rtl/pipe_stage_regs_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs_pkg
// Shared definitions for the miniRV pipeline-register slice:
//   - writeback-select encodings consumed by the forwarding unit
//   - reset / flush defaults for PC and IF/ID
//   - packed tuples carried across each stage boundary
// -----------------------------------------------------------------------------
package pipe_stage_regs_pkg;

    localparam logic [2:0] WB_SEL_IMM   = 3'd0;
    localparam logic [2:0] WB_SEL_PCIMM = 3'd1;
    localparam logic [2:0] WB_SEL_PC4   = 3'd2;
    localparam logic [2:0] WB_SEL_DRAM  = 3'd3;
    localparam logic [2:0] WB_SEL_ALU   = 3'd4;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    // addi x0,x0,0
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic [2:0]  wb_sel;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [31:0] pcimm;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic [2:0]  wb_sel;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [31:0] pcimm;
        logic [31:0] pc4;
        logic [31:0] alu_c;
        logic [31:0] rd2;
    } ex_dm_t;

    typedef struct packed {
        logic        valid;
        logic        rf_we;
        logic [2:0]  wb_sel;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [31:0] pcimm;
        logic [31:0] pc4;
        logic [31:0] alu_c;
        logic [31:0] rd_out;
    } dm_wb_t;

endpackage

// File: rtl/pipe_stage_regs_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Generic pipeline register with async active-low reset, hold and bubble load.
// Priority: reset > bubble > hold > load.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   async reset, active-low (loads RST_VAL)
//   hold    in   1 = keep current contents
//   bubble  in   1 = load BUBBLE_VAL (overrides hold)
//   d       in   next value
//   q       out  registered value
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int             W          = 32,
    parameter logic [W-1:0]   RST_VAL    = '0,
    parameter logic [W-1:0]   BUBBLE_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (bubble) begin
            q <= BUBBLE_VAL;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
// PC, IF/ID, ID/EX, EX/DM and DM/WB registers of the 5-stage miniRV core.
// Exposes each stage's writeback tuple to the forwarding unit and obeys its
// stall/bubble commands plus the branch/jump flush resolved in EX.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   npc_i, inst_i              next PC and fetched instruction
//   keep_pc_i, keep_if_id_i    hold PC / IF/ID (load-use stall)
//   flash_id_ex_i              active-low: 0 = bubble into ID/EX
//   br_flush_i                 taken branch/jump: redirect PC, kill IF/ID, ID/EX
//   *_id_i                     ID-stage tuple and operands
//   alu_c_ex_i, rd_out_dm_i    EX ALU result, DM read data
//   pc_o, *_if_id_o            fetch PC and IF/ID contents
//   *_ex_o, *_dm_o, *_wb_o     ID/EX, EX/DM, DM/WB contents
//   valid_wb_o                 WB slot holds a real instruction
// -----------------------------------------------------------------------------
module pipe_stage_regs
    import pipe_stage_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc_i,
    input  logic [31:0] inst_i,
    input  logic        keep_pc_i,
    input  logic        keep_if_id_i,
    input  logic        flash_id_ex_i,
    input  logic        br_flush_i,
    input  logic        rf_we_id_i,
    input  logic [2:0]  wb_sel_id_i,
    input  logic [4:0]  wR_id_i,
    input  logic [31:0] imm_id_i,
    input  logic [31:0] pcimm_id_i,
    input  logic [31:0] pc4_id_i,
    input  logic [31:0] rD1_id_i,
    input  logic [31:0] rD2_id_i,
    input  logic [31:0] alu_c_ex_i,
    input  logic [31:0] rd_out_dm_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_if_id_o,
    output logic [31:0] pc_if_id_o,
    output logic        rf_we_ex_o,
    output logic [2:0]  wb_sel_ex_o,
    output logic [4:0]  wR_ex_o,
    output logic [31:0] imm_ex_o,
    output logic [31:0] pcimm_ex_o,
    output logic [31:0] pc4_ex_o,
    output logic [31:0] rD1_ex_o,
    output logic [31:0] rD2_ex_o,
    output logic        rf_we_dm_o,
    output logic [2:0]  wb_sel_dm_o,
    output logic [4:0]  wR_dm_o,
    output logic [31:0] imm_dm_o,
    output logic [31:0] pcimm_dm_o,
    output logic [31:0] pc4_dm_o,
    output logic [31:0] alu_c_dm_o,
    output logic [31:0] rD2_dm_o,
    output logic        rf_we_wb_o,
    output logic [2:0]  wb_sel_wb_o,
    output logic [4:0]  wR_wb_o,
    output logic [31:0] imm_wb_o,
    output logic [31:0] pcimm_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [31:0] alu_c_wb_o,
    output logic [31:0] rd_out_wb_o,
    output logic        valid_wb_o
);

    // Reset and flush both leave IF/ID holding a NOP marked invalid.
    localparam if_id_t IF_ID_IDLE = '{valid: 1'b0, inst: NOP_INST, pc: 32'h0};

    if_id_t if_id_d, if_id_q;
    id_ex_t id_ex_d, id_ex_q;
    ex_dm_t ex_dm_d, ex_dm_q;
    dm_wb_t dm_wb_d, dm_wb_q;

    logic pc_hold;
    logic id_ex_bubble;

    // A flush must redirect even when the forwarding unit asks for a hold.
    assign pc_hold      = keep_pc_i & ~br_flush_i;
    assign id_ex_bubble = br_flush_i | ~flash_id_ex_i;

    pipe_reg #(
        .W          (32),
        .RST_VAL    (RESET_PC),
        .BUBBLE_VAL (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (pc_hold),
        .bubble (1'b0),
        .d      (npc_i),
        .q      (pc_o)
    );

    assign if_id_d = '{valid: 1'b1, inst: inst_i, pc: pc_o};

    pipe_reg #(
        .W          ($bits(if_id_t)),
        .RST_VAL    (IF_ID_IDLE),
        .BUBBLE_VAL (IF_ID_IDLE)
    ) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (keep_if_id_i),
        .bubble (br_flush_i),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    // Validity follows the IF/ID slot so a flushed NOP never commits.
    assign id_ex_d = '{
        valid:  if_id_q.valid,
        rf_we:  rf_we_id_i,
        wb_sel: wb_sel_id_i,
        wr:     wR_id_i,
        imm:    imm_id_i,
        pcimm:  pcimm_id_i,
        pc4:    pc4_id_i,
        rd1:    rD1_id_i,
        rd2:    rD2_id_i
    };

    pipe_reg #(
        .W          ($bits(id_ex_t)),
        .RST_VAL    ('0),
        .BUBBLE_VAL ('0)
    ) u_id_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (id_ex_bubble),
        .d      (id_ex_d),
        .q      (id_ex_q)
    );

    assign ex_dm_d = '{
        valid:  id_ex_q.valid,
        rf_we:  id_ex_q.rf_we,
        wb_sel: id_ex_q.wb_sel,
        wr:     id_ex_q.wr,
        imm:    id_ex_q.imm,
        pcimm:  id_ex_q.pcimm,
        pc4:    id_ex_q.pc4,
        alu_c:  alu_c_ex_i,
        rd2:    id_ex_q.rd2
    };

    pipe_reg #(
        .W          ($bits(ex_dm_t)),
        .RST_VAL    ('0),
        .BUBBLE_VAL ('0)
    ) u_ex_dm (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (ex_dm_d),
        .q      (ex_dm_q)
    );

    assign dm_wb_d = '{
        valid:  ex_dm_q.valid,
        rf_we:  ex_dm_q.rf_we,
        wb_sel: ex_dm_q.wb_sel,
        wr:     ex_dm_q.wr,
        imm:    ex_dm_q.imm,
        pcimm:  ex_dm_q.pcimm,
        pc4:    ex_dm_q.pc4,
        alu_c:  ex_dm_q.alu_c,
        rd_out: rd_out_dm_i
    };

    pipe_reg #(
        .W          ($bits(dm_wb_t)),
        .RST_VAL    ('0),
        .BUBBLE_VAL ('0)
    ) u_dm_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (1'b0),
        .d      (dm_wb_d),
        .q      (dm_wb_q)
    );

    assign inst_if_id_o = if_id_q.inst;
    assign pc_if_id_o   = if_id_q.pc;

    assign rf_we_ex_o   = id_ex_q.rf_we;
    assign wb_sel_ex_o  = id_ex_q.wb_sel;
    assign wR_ex_o      = id_ex_q.wr;
    assign imm_ex_o     = id_ex_q.imm;
    assign pcimm_ex_o   = id_ex_q.pcimm;
    assign pc4_ex_o     = id_ex_q.pc4;
    assign rD1_ex_o     = id_ex_q.rd1;
    assign rD2_ex_o     = id_ex_q.rd2;

    assign rf_we_dm_o   = ex_dm_q.rf_we;
    assign wb_sel_dm_o  = ex_dm_q.wb_sel;
    assign wR_dm_o      = ex_dm_q.wr;
    assign imm_dm_o     = ex_dm_q.imm;
    assign pcimm_dm_o   = ex_dm_q.pcimm;
    assign pc4_dm_o     = ex_dm_q.pc4;
    assign alu_c_dm_o   = ex_dm_q.alu_c;
    assign rD2_dm_o     = ex_dm_q.rd2;

    assign rf_we_wb_o   = dm_wb_q.rf_we;
    assign wb_sel_wb_o  = dm_wb_q.wb_sel;
    assign wR_wb_o      = dm_wb_q.wr;
    assign imm_wb_o     = dm_wb_q.imm;
    assign pcimm_wb_o   = dm_wb_q.pcimm;
    assign pc4_wb_o     = dm_wb_q.pc4;
    assign alu_c_wb_o   = dm_wb_q.alu_c;
    assign rd_out_wb_o  = dm_wb_q.rd_out;
    assign valid_wb_o   = dm_wb_q.valid;

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;
    import pipe_stage_regs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc_i, inst_i;
    logic        keep_pc_i, keep_if_id_i, flash_id_ex_i, br_flush_i;
    logic        rf_we_id_i;
    logic [2:0]  wb_sel_id_i;
    logic [4:0]  wR_id_i;
    logic [31:0] imm_id_i, pcimm_id_i, pc4_id_i, rD1_id_i, rD2_id_i;
    logic [31:0] alu_c_ex_i, rd_out_dm_i;
    logic [31:0] pc_o, inst_if_id_o, pc_if_id_o;
    logic        rf_we_ex_o, rf_we_dm_o, rf_we_wb_o, valid_wb_o;
    logic [2:0]  wb_sel_ex_o, wb_sel_dm_o, wb_sel_wb_o;
    logic [4:0]  wR_ex_o, wR_dm_o, wR_wb_o;
    logic [31:0] imm_ex_o, pcimm_ex_o, pc4_ex_o, rD1_ex_o, rD2_ex_o;
    logic [31:0] imm_dm_o, pcimm_dm_o, pc4_dm_o, alu_c_dm_o, rD2_dm_o;
    logic [31:0] imm_wb_o, pcimm_wb_o, pc4_wb_o, alu_c_wb_o, rd_out_wb_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_regs dut (
        .clk(clk), .rst_n(rst_n), .npc_i(npc_i), .inst_i(inst_i),
        .keep_pc_i(keep_pc_i), .keep_if_id_i(keep_if_id_i),
        .flash_id_ex_i(flash_id_ex_i), .br_flush_i(br_flush_i),
        .rf_we_id_i(rf_we_id_i), .wb_sel_id_i(wb_sel_id_i), .wR_id_i(wR_id_i),
        .imm_id_i(imm_id_i), .pcimm_id_i(pcimm_id_i), .pc4_id_i(pc4_id_i),
        .rD1_id_i(rD1_id_i), .rD2_id_i(rD2_id_i),
        .alu_c_ex_i(alu_c_ex_i), .rd_out_dm_i(rd_out_dm_i),
        .pc_o(pc_o), .inst_if_id_o(inst_if_id_o), .pc_if_id_o(pc_if_id_o),
        .rf_we_ex_o(rf_we_ex_o), .wb_sel_ex_o(wb_sel_ex_o), .wR_ex_o(wR_ex_o),
        .imm_ex_o(imm_ex_o), .pcimm_ex_o(pcimm_ex_o), .pc4_ex_o(pc4_ex_o),
        .rD1_ex_o(rD1_ex_o), .rD2_ex_o(rD2_ex_o),
        .rf_we_dm_o(rf_we_dm_o), .wb_sel_dm_o(wb_sel_dm_o), .wR_dm_o(wR_dm_o),
        .imm_dm_o(imm_dm_o), .pcimm_dm_o(pcimm_dm_o), .pc4_dm_o(pc4_dm_o),
        .alu_c_dm_o(alu_c_dm_o), .rD2_dm_o(rD2_dm_o),
        .rf_we_wb_o(rf_we_wb_o), .wb_sel_wb_o(wb_sel_wb_o), .wR_wb_o(wR_wb_o),
        .imm_wb_o(imm_wb_o), .pcimm_wb_o(pcimm_wb_o), .pc4_wb_o(pc4_wb_o),
        .alu_c_wb_o(alu_c_wb_o), .rd_out_wb_o(rd_out_wb_o),
        .valid_wb_o(valid_wb_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic we, input logic [2:0] sel, input logic [4:0] wr,
                          input logic [31:0] imm, input logic [31:0] pc4, input logic [31:0] rd2);
        rf_we_id_i  = we;
        wb_sel_id_i = sel;
        wR_id_i     = wr;
        imm_id_i    = imm;
        pcimm_id_i  = imm + 32'h100;
        pc4_id_i    = pc4;
        rD1_id_i    = rd2 ^ 32'hFFFF;
        rD2_id_i    = rd2;
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        npc_i = 32'h4; inst_i = 32'hA0;
        keep_pc_i = 1'b0; keep_if_id_i = 1'b0; flash_id_ex_i = 1'b1; br_flush_i = 1'b0;
        set_id(1'b0, WB_SEL_IMM, 5'd0, 32'h0, 32'h0, 32'h0);
        alu_c_ex_i = 32'h0; rd_out_dm_i = 32'h0;

        // Reset state
        #12;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_inst", inst_if_id_o, 32'h13);
        chk("rst_pc_if_id", pc_if_id_o, 32'h0);
        chk("rst_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h0);
        chk("rst_valid_wb", {31'h0, valid_wb_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge 1: first fetch into IF/ID
        tick();
        chk("e1_pc", pc_o, 32'h4);
        chk("e1_inst", inst_if_id_o, 32'hA0);
        chk("e1_pc_if_id", pc_if_id_o, 32'h0);

        // Edge 2: A0 issues from ID as rf_we=1, wR=5, ALU writeback
        npc_i = 32'h8; inst_i = 32'hA4;
        set_id(1'b1, WB_SEL_ALU, 5'd5, 32'h111, 32'h4, 32'h222);
        tick();
        chk("e2_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h1);
        chk("e2_wR_ex", {27'h0, wR_ex_o}, 32'd5);
        chk("e2_wb_sel_ex", {29'h0, wb_sel_ex_o}, 32'd4);
        chk("e2_rD1_ex", rD1_ex_o, 32'h222 ^ 32'hFFFF);

        // Edge 3: ALU result arrives in EX
        npc_i = 32'hC; inst_i = 32'hA8;
        set_id(1'b0, WB_SEL_IMM, 5'd0, 32'h0, 32'h0, 32'h0);
        alu_c_ex_i = 32'h1234;
        tick();
        chk("e3_rf_we_dm", {31'h0, rf_we_dm_o}, 32'h1);
        chk("e3_alu_c_dm", alu_c_dm_o, 32'h1234);
        chk("e3_rD2_dm", rD2_dm_o, 32'h222);

        // Edge 4: reaches WB
        npc_i = 32'h10; inst_i = 32'hAC;
        alu_c_ex_i = 32'h0; rd_out_dm_i = 32'hDEAD;
        tick();
        chk("e4_rf_we_wb", {31'h0, rf_we_wb_o}, 32'h1);
        chk("e4_wR_wb", {27'h0, wR_wb_o}, 32'd5);
        chk("e4_alu_c_wb", alu_c_wb_o, 32'h1234);
        chk("e4_imm_wb", imm_wb_o, 32'h111);
        chk("e4_pcimm_wb", pcimm_wb_o, 32'h211);
        chk("e4_rd_out_wb", rd_out_wb_o, 32'hDEAD);
        chk("e4_valid_wb", {31'h0, valid_wb_o}, 32'h1);
        chk("e4_pc", pc_o, 32'h10);

        // Edge 5: load-use stall with pc_o=0x10
        rd_out_dm_i = 32'h0;
        keep_pc_i = 1'b1; keep_if_id_i = 1'b1; flash_id_ex_i = 1'b0;
        npc_i = 32'h14; inst_i = 32'hB0;
        set_id(1'b1, WB_SEL_DRAM, 5'd7, 32'h0, 32'h10, 32'h0);
        tick();
        chk("stall_pc", pc_o, 32'h10);
        chk("stall_inst", inst_if_id_o, 32'hAC);
        chk("stall_pc_if_id", pc_if_id_o, 32'hC);
        chk("stall_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h0);
        chk("stall_wR_ex", {27'h0, wR_ex_o}, 32'h0);

        // Edge 6: flow resumes, AC issues
        keep_pc_i = 1'b0; keep_if_id_i = 1'b0; flash_id_ex_i = 1'b1;
        set_id(1'b1, WB_SEL_PC4, 5'd7, 32'h0, 32'h10, 32'h0);
        tick();
        chk("resume_pc", pc_o, 32'h14);
        chk("resume_inst", inst_if_id_o, 32'hB0);
        chk("resume_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h1);
        chk("resume_wR_ex", {27'h0, wR_ex_o}, 32'd7);
        chk("bubble_rf_we_dm", {31'h0, rf_we_dm_o}, 32'h0);
        chk("pre_bubble_valid_wb", {31'h0, valid_wb_o}, 32'h1);

        // Edge 7: bubble from edge 5 reaches WB
        npc_i = 32'h18; inst_i = 32'hB4;
        set_id(1'b0, WB_SEL_IMM, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("bubble_valid_wb", {31'h0, valid_wb_o}, 32'h0);
        chk("bubble_rf_we_wb", {31'h0, rf_we_wb_o}, 32'h0);

        // Edge 8: branch flush; older EX/DM (AC) still advances to WB
        br_flush_i = 1'b1; npc_i = 32'h80;
        set_id(1'b1, WB_SEL_ALU, 5'd9, 32'h0, 32'h0, 32'h0);
        tick();
        chk("flush_pc", pc_o, 32'h80);
        chk("flush_inst", inst_if_id_o, 32'h13);
        chk("flush_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h0);
        chk("flush_wR_ex", {27'h0, wR_ex_o}, 32'h0);
        chk("flush_rf_we_wb", {31'h0, rf_we_wb_o}, 32'h1);
        chk("flush_wR_wb", {27'h0, wR_wb_o}, 32'd7);
        chk("flush_wb_sel_wb", {29'h0, wb_sel_wb_o}, 32'd2);
        chk("flush_pc4_wb", pc4_wb_o, 32'h10);
        chk("after_bubble_valid_wb", {31'h0, valid_wb_o}, 32'h1);

        // Edge 9: fetch at branch target
        br_flush_i = 1'b0; npc_i = 32'h84; inst_i = 32'hC0;
        set_id(1'b0, WB_SEL_IMM, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("target_pc", pc_o, 32'h84);
        chk("target_inst", inst_if_id_o, 32'hC0);
        chk("target_pc_if_id", pc_if_id_o, 32'h80);

        // Edge 10: flush during stall -- flush wins, PC redirected
        br_flush_i = 1'b1; keep_pc_i = 1'b1; keep_if_id_i = 1'b1; flash_id_ex_i = 1'b0;
        npc_i = 32'h200;
        set_id(1'b1, WB_SEL_ALU, 5'd3, 32'h5, 32'h0, 32'h0);
        tick();
        chk("fstall_pc", pc_o, 32'h200);
        chk("fstall_inst", inst_if_id_o, 32'h13);
        chk("fstall_pc_if_id", pc_if_id_o, 32'h0);
        chk("fstall_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h0);
        chk("fstall_imm_ex", imm_ex_o, 32'h0);
        chk("flushed_valid_wb", {31'h0, valid_wb_o}, 32'h0);

        // Edge 11
        br_flush_i = 1'b0; keep_pc_i = 1'b0; keep_if_id_i = 1'b0; flash_id_ex_i = 1'b1;
        npc_i = 32'h204; inst_i = 32'hD0;
        set_id(1'b0, WB_SEL_IMM, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("post_pc", pc_o, 32'h204);
        chk("post_inst", inst_if_id_o, 32'hD0);

        // Edge 12: flush-during-stall bubble reaches WB; D0 issues
        npc_i = 32'h208; inst_i = 32'hD4;
        set_id(1'b1, WB_SEL_ALU, 5'd6, 32'h0, 32'h0, 32'h0);
        tick();
        chk("fbubble_valid_wb", {31'h0, valid_wb_o}, 32'h0);
        chk("fbubble_rf_we_wb", {31'h0, rf_we_wb_o}, 32'h0);
        chk("pre_rst_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h1);
        chk("pre_rst_pc", pc_o, 32'h208);

        // Reset mid-run, between edges, takes effect immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc_o, 32'h0);
        chk("mid_rst_inst", inst_if_id_o, 32'h13);
        chk("mid_rst_rf_we_ex", {31'h0, rf_we_ex_o}, 32'h0);
        chk("mid_rst_rf_we_dm", {31'h0, rf_we_dm_o}, 32'h0);
        chk("mid_rst_rf_we_wb", {31'h0, rf_we_wb_o}, 32'h0);
        chk("mid_rst_valid_wb", {31'h0, valid_wb_o}, 32'h0);
        tick();
        chk("held_rst_pc", pc_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        npc_i = 32'h300;
        tick();
        chk("rst_release_pc", pc_o, 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Producer side of the hazard/forwarding interface: holds PC, IF/ID, ID/EX, EX/DM and DM/WB pipeline registers for the 5-stage miniRV core.
- Generates the per-stage writeback tuples (rf_we, wb_sel, wR, imm, pcimm, pc4, alu_c, rd_out) that the forwarding unit consumes.
- Obeys the forwarding unit's stall/bubble commands (keep_pc, keep_if_id, active-low flash_id_ex) plus a branch/jump flush from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, instruction injected into IF/ID on flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock, all registers on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- npc_i  in  32  next PC from next-PC logic.
- inst_i  in  32  instruction fetched at pc_o.
- keep_pc_i  in  1  1 = hold PC.
- keep_if_id_i  in  1  1 = hold IF/ID.
- flash_id_ex_i  in  1  active-low: 0 = load bubble into ID/EX.
- br_flush_i  in  1  1 = taken branch/jump resolved in EX; kill IF/ID and ID/EX.
- rf_we_id_i  in  1  ID-stage write enable.
- wb_sel_id_i  in  3  ID-stage writeback select (0 imm, 1 pcimm, 2 pc4, 3 load data, other alu).
- wR_id_i  in  5  ID-stage destination register.
- imm_id_i, pcimm_id_i, pc4_id_i, rD1_id_i, rD2_id_i  in  32 each  ID-stage operands.
- alu_c_ex_i  in  32  ALU result computed in EX.
- rd_out_dm_i  in  32  data-memory read data in DM.
- pc_o  out  32  current fetch PC.
- inst_if_id_o, pc_if_id_o  out  32  IF/ID contents.
- rf_we_ex_o, wb_sel_ex_o, wR_ex_o, imm_ex_o, pcimm_ex_o, pc4_ex_o, rD1_ex_o, rD2_ex_o  out  1/3/5/32...  ID/EX contents.
- rf_we_dm_o, wb_sel_dm_o, wR_dm_o, imm_dm_o, pcimm_dm_o, pc4_dm_o, alu_c_dm_o, rD2_dm_o  out  EX/DM contents.
- rf_we_wb_o, wb_sel_wb_o, wR_wb_o, imm_wb_o, pcimm_wb_o, pc4_wb_o, alu_c_wb_o, rd_out_wb_o  out  DM/WB contents.
- valid_wb_o  out  1  WB slot holds a real (non-bubble) instruction; used by the commit/trace logic.

Behaviour:
- Reset (rst_n=0, asynchronous): pc_o=RESET_PC; inst_if_id_o=NOP_INST; every other output 0, including all rf_we_* and valid bits. Deassertion takes effect at the next rising clk.
- Each stage carries an internal valid bit. Bubble = valid 0, rf_we 0, wR 0, wb_sel 0, all data 0.
- PC update priority:
  1. br_flush_i: PC <= npc_i.
  2. keep_pc_i: hold.
  3. Otherwise: PC <= npc_i.
- IF/ID update priority:
  1. br_flush_i: inst <= NOP_INST, valid 0.
  2. keep_if_id_i: hold.
  3. Otherwise: load inst_i and pc_o, valid 1.
- ID/EX update priority:
  1. br_flush_i or flash_id_ex_i=0: bubble.
  2. Otherwise: load ID-stage inputs, valid <= IF/ID valid.
- EX/DM and DM/WB never stall and always advance.
  - EX/DM captures the ID/EX tuple plus alu_c_ex_i.
  - DM/WB captures the EX/DM tuple plus rd_out_dm_i.
- br_flush_i together with a load-use stall: flush wins; PC is redirected, no hold.
- Latency: an instruction accepted into IF/ID appears at WB 3 cycles later when no stall occurs. A load-use stall adds exactly 1 cycle.
- Destination x0: registers store wR=0 unchanged and do not mask rf_we; the consumer qualifies on wR≠0.
- PC increments are not computed here; arithmetic is left to next-PC logic. npc_i is taken as-is, with no alignment check.

Decomposition:
- Shared package/header holds:
  - WB_SEL_IMM=0, WB_SEL_PCIMM=1, WB_SEL_PC4=2, WB_SEL_DRAM=3, WB_SEL_ALU=4.
  - RESET_PC and NOP_INST defaults.
- One natural sub-module: pipe_reg, a generic width-parameterised register with async active-low reset, hold enable and bubble-load. It is instantiated once per stage boundary.

Test Plan:
- Reset mid-run: drop rst_n between edges -> pc_o=0, all rf_we_*=0, inst_if_id_o=0x00000013 immediately, without waiting for a clock edge.
- Straight-line flow: ID issues rf_we=1, wR=5, wb_sel=4; alu_c_ex_i=0x1234 in the next cycle -> rf_we_wb_o=1, wR_wb_o=5, alu_c_wb_o=0x1234 three edges later.
- Load-use stall: one cycle of keep_pc_i=1, keep_if_id_i=1, flash_id_ex_i=0 with pc_o=0x10 -> pc_o stays 0x10, IF/ID unchanged, rf_we_ex_o=0 next cycle, and flow resumes.
- Branch flush: br_flush_i=1, npc_i=0x80 -> pc_o=0x80, inst_if_id_o=0x13, rf_we_ex_o=0, while older EX/DM content still advances to WB.
- Flush during stall: br_flush_i=1 and keep_pc_i=1 in the same cycle -> pc_o=npc_i, both the IF/ID and ID/EX stages become bubbles.
- Bubble propagation: a single bubble injected into ID/EX -> valid_wb_o=0 exactly 2 cycles later and rf_we_wb_o=0 for that cycle only.
